// File: rtl/period_scheduler.sv
// Class-period sequencer: tracks the active period from the timer's minute-of-day.
// Latency: 1 cycle from a new timer value (or SEEK) to registered outputs/pulses.
// Backpressure: none; the host table port accepts one write per cycle at any time.
//
// Ports: clk/rst_n (async active-low); enable gates the schedule; hour/minute is the
// timer value; cfg_we/cfg_addr/cfg_start/cfg_len write one table entry; outputs are
// period_idx, period_act, period_start/period_end pulses, day_done level and warn pulse.
// Optional feature macro: SCHED_WARN_EN builds the pre-end warn pulse; otherwise warn = 0.
module period_scheduler #(
    parameter int NUM_PERIODS = 8,
    parameter int LEN_W       = 7,
    parameter int WARN_MIN    = 5,
    localparam int IDX_W      = (NUM_PERIODS > 1) ? $clog2(NUM_PERIODS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [4:0]       hour,
    input  logic [5:0]       minute,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [10:0]      cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic [IDX_W-1:0] period_idx,
    output logic             period_act,
    output logic             period_start,
    output logic             period_end,
    output logic             day_done,
    output logic             warn
);

    typedef enum logic [2:0] {S_IDLE, S_SEEK, S_WAIT, S_IN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [10:0]      now_q, now_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             act_q, act_d;
    logic             done_q, done_d;
    logic             start_pls_q, start_pls_d;
    logic             end_pls_q, end_pls_d;
    logic [10:0]      start_q [NUM_PERIODS];
    logic [10:0]      start_d [NUM_PERIODS];
    logic [LEN_W-1:0] len_q   [NUM_PERIODS];
    logic [LEN_W-1:0] len_d   [NUM_PERIODS];

    // End of an entry; anything past the last minute of the day saturates at 1440.
    function automatic logic [10:0] end_of(input logic [10:0] s, input logic [LEN_W-1:0] l);
        logic [11:0] sum;
        sum = {1'b0, s} + 12'(l);
        return (sum > 12'd1439) ? 11'd1440 : sum[10:0];
    endfunction

    logic [10:0]      now_in;
    logic             now_vld;
    logic             now_chg;
    logic [10:0]      cur_start;
    logic [10:0]      cur_end;
    logic             seek_hit;
    logic [IDX_W-1:0] seek_i;
    logic             next_hit;
    logic [IDX_W-1:0] next_i;

    assign now_in    = 11'(hour) * 11'd60 + 11'(minute);
    assign now_vld   = (hour <= 5'd23) && (minute <= 6'd59);
    assign now_chg   = (now_in != now_q);
    assign cur_start = start_q[idx_q];
    assign cur_end   = end_of(start_q[idx_q], len_q[idx_q]);

    // Candidate searches. Descending loops leave the lowest matching index.
    // The "next" search only accepts entries whose start is still ahead of (or at)
    // now, so overlapped entries that can no longer open are skipped.
    always_comb begin
        seek_hit = 1'b0;
        seek_i   = '0;
        next_hit = 1'b0;
        next_i   = '0;
        for (int i = NUM_PERIODS - 1; i >= 0; i--) begin
            if ((len_q[i] != '0) && (end_of(start_q[i], len_q[i]) > now_in)) begin
                seek_hit = 1'b1;
                seek_i   = IDX_W'(i);
                if ((IDX_W'(i) > idx_q) && (start_q[i] >= now_in)) begin
                    next_hit = 1'b1;
                    next_i   = IDX_W'(i);
                end
            end
        end
    end

    // Table write port; out-of-range addresses match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_PERIODS; i++) begin
            start_d[i] = start_q[i];
            len_d[i]   = len_q[i];
            if (cfg_we && (cfg_addr == 4'(i))) begin
                start_d[i] = cfg_start;
                len_d[i]   = cfg_len;
            end
        end
    end

`ifdef SCHED_WARN_EN
    localparam logic [10:0] WARN_OFS = 11'(WARN_MIN);
    logic warn_q, warn_d;
    logic [LEN_W-1:0] cur_len;
    assign cur_len = len_q[idx_q];
`endif

    always_comb begin
        state_d     = state_q;
        now_d       = now_q;
        idx_d       = idx_q;
        act_d       = act_q;
        done_d      = done_q;
        start_pls_d = 1'b0;
        end_pls_d   = 1'b0;
`ifdef SCHED_WARN_EN
        warn_d      = 1'b0;
`endif
        // An out-of-range timer value freezes everything except the pulses.
        if (now_vld) begin
            now_d = now_in;
            if (!enable) begin
                state_d = S_IDLE;
                act_d   = 1'b0;
                done_d  = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_SEEK;
                    S_SEEK: begin
                        if (!seek_hit) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = seek_i;
                            if (start_q[seek_i] <= now_in) begin
                                state_d     = S_IN;
                                act_d       = 1'b1;
                                start_pls_d = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (now_chg && (now_in == cur_start)) begin
                            state_d     = S_IN;
                            act_d       = 1'b1;
                            start_pls_d = 1'b1;
                        end
                    end
                    S_IN: begin
                        if (now_chg) begin
                            if (now_in >= cur_end) begin
                                end_pls_d = 1'b1;
                                act_d     = 1'b0;
                                if (next_hit) begin
                                    idx_d = next_i;
                                    // Back-to-back entry opens in the same cycle.
                                    if (start_q[next_i] == now_in) begin
                                        act_d       = 1'b1;
                                        start_pls_d = 1'b1;
                                    end else begin
                                        state_d = S_WAIT;
                                    end
                                end else begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                end
                            end
`ifdef SCHED_WARN_EN
                            else if ((now_in == cur_end - WARN_OFS) && (int'(cur_len) > WARN_MIN)) begin
                                warn_d = 1'b1;
                            end
`endif
                        end
                    end
                    S_DONE: begin
                        // A smaller minute-of-day than last seen means midnight passed.
                        if (now_in < now_q) begin
                            state_d = S_SEEK;
                            done_d  = 1'b0;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            now_q       <= '0;
            idx_q       <= '0;
            act_q       <= 1'b0;
            done_q      <= 1'b0;
            start_pls_q <= 1'b0;
            end_pls_q   <= 1'b0;
            for (int i = 0; i < NUM_PERIODS; i++) begin
                start_q[i] <= '0;
                len_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            now_q       <= now_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            done_q      <= done_d;
            start_pls_q <= start_pls_d;
            end_pls_q   <= end_pls_d;
            for (int i = 0; i < NUM_PERIODS; i++) begin
                start_q[i] <= start_d[i];
                len_q[i]   <= len_d[i];
            end
        end
    end

`ifdef SCHED_WARN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) warn_q <= 1'b0;
        else        warn_q <= warn_d;
    end
    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

    assign period_idx   = idx_q;
    assign period_act   = act_q;
    assign period_start = start_pls_q;
    assign period_end   = end_pls_q;
    assign day_done     = done_q;

endmodule

// File: tb/tb_period_scheduler.sv
// Self-checking bench for period_scheduler: table-driven day sequence plus
// hand-written sequences for back-to-back, enable/reset and table-edit corners.
// Outputs are sampled 1 time unit after the rising edge.
module tb_period_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  hour = 5'd0;
    logic [5:0]  minute = 6'd0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [10:0] cfg_start = 11'd0;
    logic [6:0]  cfg_len = 7'd0;
    logic [2:0]  period_idx;
    logic        period_act, period_start, period_end, day_done, warn;

    int checks = 0;
    int errors = 0;

`ifdef SCHED_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    period_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .hour(hour), .minute(minute),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .period_idx(period_idx), .period_act(period_act), .period_start(period_start),
        .period_end(period_end), .day_done(day_done), .warn(warn)
    );

    always #5 clk = ~clk;

    // Packed view: {idx[2:0], act, start, end, done, warn}
    function automatic logic [7:0] mk(input int idx, input bit a, input bit s,
                                      input bit e, input bit d, input bit w);
        return {3'(idx), a, s, e, d, w};
    endfunction

    function automatic logic [7:0] outs();
        return {period_idx, period_act, period_start, period_end, day_done, warn};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {idx,act,start,end,done,warn}=%b_%b required %b_%b",
                     name, got[7:5], got[4:0], exp[7:5], exp[4:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int h, input int m, input bit en);
        hour   = 5'(h);
        minute = 6'(m);
        enable = en;
        tick();
    endtask

    task automatic cfg_write(input int a, input int s, input int l);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_start = 11'(s);
        cfg_len   = 7'(l);
        tick();
        cfg_we    = 1'b0;
    endtask

    // Called just after a sampling point, well away from any clock edge.
    task automatic do_reset();
        enable = 1'b0;
        cfg_we = 1'b0;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
    endtask

    typedef struct {
        int         h;
        int         m;
        bit         en;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Full day with two periods, rollover at midnight.
        vecs[0]  = '{7, 58, 1'b1, mk(0,0,0,0,0,0), "enable_to_seek"};
        vecs[1]  = '{7, 58, 1'b1, mk(0,0,0,0,0,0), "seek_to_wait"};
        vecs[2]  = '{7, 59, 1'b1, mk(0,0,0,0,0,0), "wait_0759"};
        vecs[3]  = '{8,  0, 1'b1, mk(0,1,1,0,0,0), "start_p0"};
        vecs[4]  = '{8,  0, 1'b1, mk(0,1,0,0,0,0), "start_pulse_drop"};
        vecs[5]  = '{8, 45, 1'b1, mk(0,1,0,0,0,WARN_ON), "warn_0845"};
        vecs[6]  = '{8, 46, 1'b1, mk(0,1,0,0,0,0), "no_warn_0846"};
        vecs[7]  = '{8, 50, 1'b1, mk(1,0,0,1,0,0), "end_p0"};
        vecs[8]  = '{8, 51, 1'b1, mk(1,0,0,0,0,0), "wait_p1"};
        vecs[9]  = '{9,  0, 1'b1, mk(1,1,1,0,0,0), "start_p1"};
        vecs[10] = '{9, 50, 1'b1, mk(1,0,0,1,1,0), "end_p1_done"};
        vecs[11] = '{9, 51, 1'b1, mk(1,0,0,0,1,0), "done_holds"};
        vecs[12] = '{23, 59, 1'b1, mk(1,0,0,0,1,0), "done_2359"};
        vecs[13] = '{0,  0, 1'b1, mk(1,0,0,0,0,0), "wrap_to_seek"};
        vecs[14] = '{0,  0, 1'b1, mk(0,0,0,0,0,0), "seek_to_wait_idx0"};

        #1 rst_n = 1'b0;
        #1 check("reset_outputs", mk(0,0,0,0,0,0));
        #1 rst_n = 1'b1;

        hour = 5'd7; minute = 6'd58;
        cfg_write(0, 480, 50);
        cfg_write(1, 540, 50);
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].h, vecs[i].m, vecs[i].en);
            check(vecs[i].name, vecs[i].exp);
        end

        // Back-to-back: end of entry 0 and start of entry 1 share a cycle.
        do_reset();
        hour = 5'd8; minute = 6'd58;
        cfg_write(0, 480, 60);
        cfg_write(1, 540, 45);
        apply(8, 58, 1'b1);
        check("b2b_seek", mk(0,0,0,0,0,0));
        apply(8, 58, 1'b1);
        check("b2b_seek_in", mk(0,1,1,0,0,0));
        apply(8, 59, 1'b1);
        check("b2b_0859", mk(0,1,0,0,0,0));
        apply(9, 0, 1'b1);
        check("b2b_end_start", mk(1,1,1,1,0,0));

        // Enable rise mid-period, invalid hour hold, then a shortening write.
        do_reset();
        hour = 5'd8; minute = 6'd20;
        cfg_write(0, 480, 50);
        apply(8, 20, 1'b0);
        check("idle_en0", mk(0,0,0,0,0,0));
        apply(8, 20, 1'b1);
        check("rise_seek", mk(0,0,0,0,0,0));
        apply(8, 20, 1'b1);
        check("rise_in", mk(0,1,1,0,0,0));
        for (int i = 0; i < 3; i++) begin
            apply(25, 20, 1'b1);
            check("bad_hour_hold", mk(0,1,0,0,0,0));
        end
        apply(8, 21, 1'b1);
        check("after_bad_hour", mk(0,1,0,0,0,0));
        cfg_write(0, 480, 10);
        check("shorten_no_eval", mk(0,1,0,0,0,0));
        apply(8, 22, 1'b1);
        check("shorten_close", mk(0,0,0,1,1,0));

        // enable drop mid-period: no end pulse.
        do_reset();
        hour = 5'd8; minute = 6'd20;
        cfg_write(0, 480, 50);
        apply(8, 20, 1'b1);
        apply(8, 20, 1'b1);
        check("en_in", mk(0,1,1,0,0,0));
        apply(8, 21, 1'b0);
        check("en_drop_idle", mk(0,0,0,0,0,0));

        // Out-of-range table address is dropped: empty table goes straight to DONE.
        do_reset();
        hour = 5'd8; minute = 6'd20;
        cfg_write(8, 480, 50);
        apply(8, 20, 1'b1);
        apply(8, 20, 1'b1);
        check("bad_addr_done", mk(0,0,0,0,1,0));

        // Asynchronous reset mid-period clears outputs without a clock edge.
        do_reset();
        hour = 5'd8; minute = 6'd20;
        cfg_write(0, 480, 50);
        apply(8, 20, 1'b1);
        apply(8, 20, 1'b1);
        check("pre_reset_in", mk(0,1,1,0,0,0));
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(0,0,0,0,0,0));
        #1 rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
